// File: rtl/mv_pkg.sv
// mv_pkg -- shared definitions for the motion-vector selection block.
//
// Contents:
//   SAD_W / COORD_W     field widths of a row result
//   *_MSB / *_LSB       bit positions of the SAD, x and y fields in in_data
//   IN_W                total width of a row result
//   SAD_IDLE            idle pattern emitted by the row stage (never a winner)
//   CNT_W               width of the row counter
//   mv_state_e          selection FSM states
//   row_sad/row_x/row_y helpers that unpack a row result
package mv_pkg;

  localparam int SAD_W   = 12;
  localparam int COORD_W = 4;
  localparam int IN_W    = SAD_W + 2 * COORD_W;

  localparam int SAD_MSB = 19;
  localparam int SAD_LSB = 8;
  localparam int X_MSB   = 7;
  localparam int X_LSB   = 4;
  localparam int Y_MSB   = 3;
  localparam int Y_LSB   = 0;

  localparam logic [SAD_W-1:0] SAD_IDLE = 12'hFFF;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } mv_state_e;

  function automatic logic [SAD_W-1:0] row_sad(input logic [IN_W-1:0] d);
    return d[SAD_MSB:SAD_LSB];
  endfunction

  function automatic logic [COORD_W-1:0] row_x(input logic [IN_W-1:0] d);
    return d[X_MSB:X_LSB];
  endfunction

  function automatic logic [COORD_W-1:0] row_y(input logic [IN_W-1:0] d);
    return d[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/mv_select.sv
// mv_select -- picks the minimum-SAD candidate out of NUM_ROWS row results
// that make up one motion-search window, then holds it for the consumer.
//
// Parameters:
//   NUM_ROWS      rows per search window (2..16)
//   EARLY_THRESH  early-termination SAD threshold (only with the macro below)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, ACTIVE HIGH (1 = reset asserted)
//   start      one-cycle pulse: begin (or restart) a search window
//   in_valid   in_data holds a valid row result
//   in_data    row result: [19:8] SAD, [7:4] x, [3:0] y
//   out_ready  consumer accepts the result
//   out_valid  best_* holds the final window result
//   best_sad   minimum SAD of the window
//   best_x     x of the minimum
//   best_y     y of the minimum
//   busy       high while collecting rows
//   dbg_state  current FSM state, for observation only
//
// Handshake: the result transfers on the rising edge where out_valid and
// out_ready are both 1. While out_valid is high and out_ready is low, best_*
// do not change. There is no backpressure on the input: every in_valid cycle
// in COLLECT is consumed.
//
// Build option: define MV_SELECT_EARLY_TERM_EN to end a window as soon as an
// accepted row has SAD < EARLY_THRESH.
module mv_select
  import mv_pkg::*;
#(
  parameter int                NUM_ROWS     = 16,
  parameter logic [SAD_W-1:0]  EARLY_THRESH = 12'd64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [SAD_W-1:0]   best_sad,
  output logic [COORD_W-1:0] best_x,
  output logic [COORD_W-1:0] best_y,
  output logic               busy,
  output mv_state_e          dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_ROWS);

  mv_state_e          state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [COORD_W-1:0] best_x_q,   best_x_d;
  logic [COORD_W-1:0] best_y_q,   best_y_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  logic [SAD_W-1:0]   in_sad;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic [CNT_W-1:0]   cnt_inc;
  logic               row_better;
  logic               early_hit;

  assign in_sad = row_sad(in_data);
  assign in_x   = row_x(in_data);
  assign in_y   = row_y(in_data);

  // Counter saturates at NUM_ROWS so it can never wrap back to zero.
  assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

  // Strict less-than keeps the earliest row on ties. The idle pattern is
  // excluded explicitly so it can never displace the initial best value.
  assign row_better = (in_sad != SAD_IDLE) && (in_sad < best_sad_q);

`ifdef MV_SELECT_EARLY_TERM_EN
  assign early_hit = (in_sad < EARLY_THRESH);
`else
  logic thresh_unused;
  assign thresh_unused = ^EARLY_THRESH;
  assign early_hit     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;

    unique case (state_q)
      ST_IDLE: begin
        // in_valid is deliberately ignored here.
        if (start) begin
          state_d    = ST_COLLECT;
          cnt_d      = '0;
          best_sad_d = SAD_IDLE;
          best_x_d   = '0;
          best_y_d   = '0;
        end
      end

      ST_COLLECT: begin
        if (start) begin
          // Abort: restart the window; a row arriving this cycle is dropped.
          cnt_d      = '0;
          best_sad_d = SAD_IDLE;
          best_x_d   = '0;
          best_y_d   = '0;
        end else if (in_valid) begin
          cnt_d = cnt_inc;
          // Compare the row first, then decide whether the window is over.
          if (row_better) begin
            best_sad_d = in_sad;
            best_x_d   = in_x;
            best_y_d   = in_y;
          end
          if ((cnt_inc == CNT_MAX) || early_hit) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // start alone is ignored; with out_ready it chains straight into
        // the next window on the same edge as the handshake.
        if (out_ready) begin
          if (start) begin
            state_d    = ST_COLLECT;
            cnt_d      = '0;
            best_sad_d = SAD_IDLE;
            best_x_d   = '0;
            best_y_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with state_q without any output decode.
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      best_sad_q  <= SAD_IDLE;
      best_x_q    <= '0;
      best_y_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_sad_q  <= best_sad_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign best_sad  = best_sad_q;
  assign best_x    = best_x_q;
  assign best_y    = best_y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mv_select.sv
// tb_mv_select -- self-checking bench for mv_select (NUM_ROWS = 16).
// Inputs change 1 ns after a rising edge; results are sampled there or on the
// falling edge. Expected window results are queued when a window's rows are
// driven and popped by the output monitor when the handshake happens.
module tb_mv_select;
  import mv_pkg::*;

  localparam int ROWS = 16;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic [IN_W-1:0]    in_data;
  logic               out_ready;
  logic               out_valid;
  logic [SAD_W-1:0]   best_sad;
  logic [COORD_W-1:0] best_x;
  logic [COORD_W-1:0] best_y;
  logic               busy;
  mv_state_e          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IN_W-1:0] exp_q[$];

  mv_select #(.NUM_ROWS(ROWS), .EARLY_THRESH(12'd64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .best_sad  (best_sad),
    .best_x    (best_x),
    .best_y    (best_y),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got sad=%0d x=%0d y=%0d, no result expected",
                 best_sad, best_x, best_y);
      end else begin
        logic [IN_W-1:0] e;
        e = exp_q.pop_front();
        if ({best_sad, best_x, best_y} !== e) begin
          n_fail++;
          $display("FAIL result: got sad=%0d x=%0d y=%0d, expected sad=%0d x=%0d y=%0d",
                   best_sad, best_x, best_y, e[SAD_MSB:SAD_LSB], e[X_MSB:X_LSB], e[Y_MSB:Y_LSB]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_row(input logic [SAD_W-1:0] sad, input logic [COORD_W-1:0] x,
                          input logic [COORD_W-1:0] y);
    in_valid = 1'b1;
    in_data  = {sad, x, y};
    tick();
    in_valid = 1'b0;
  endtask

  // Queue the expected result, complete the handshake, confirm out_valid drops.
  task automatic take_result(input string name, input logic [SAD_W-1:0] sad,
                             input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    exp_q.push_back({sad, x, y});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s_release: out_valid=%0b state=%0d, expected 0 / IDLE", name, out_valid, dbg_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || best_sad !== 12'hFFF || best_x !== 4'd0 ||
        best_y !== 4'd0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: ov=%0b busy=%0b sad=%h x=%0d y=%0d st=%0d, expected 0 0 fff 0 0 0",
               out_valid, busy, best_sad, best_x, best_y, dbg_state);
    end
    tick(); tick();
    rst_n = 1'b0;
    // in_valid in IDLE must not start anything.
    send_row(12'd1, 4'd1, 4'd1);
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || best_sad !== 12'hFFF) begin
      n_fail++;
      $display("FAIL idle_ignore: busy=%0b ov=%0b sad=%h, expected 0 0 fff", busy, out_valid, best_sad);
    end
  endtask

  task automatic test_descending();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL desc_busy: busy=%0b, expected 1", busy);
    end
    for (int i = 0; i < ROWS; i++) begin
      send_row(12'(500 - i), 4'd3, 4'(i));
      if (i == ROWS - 2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL desc_early_valid: out_valid=%0b after row %0d, expected 0", out_valid, i);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || best_sad !== 12'd485 || best_x !== 4'd3 || best_y !== 4'd15) begin
      n_fail++;
      $display("FAIL desc_latency: ov=%0b busy=%0b sad=%0d x=%0d y=%0d, expected 1 0 485 3 15",
               out_valid, busy, best_sad, best_x, best_y);
    end
    take_result("desc", 12'd485, 4'd3, 4'd15);
  endtask

  task automatic test_tie();
    pulse_start();
    for (int i = 0; i < ROWS; i++) send_row(12'd200, 4'(i), 4'(i));
    take_result("tie", 12'd200, 4'd0, 4'd0);
  endtask

  task automatic test_hold_stall();
    logic [SAD_W-1:0]   m_sad;
    logic [COORD_W-1:0] m_x, m_y;
    logic [SAD_W-1:0]   s;
    logic [COORD_W-1:0] x;
    m_sad = 12'hFFF; m_x = '0; m_y = '0;
    pulse_start();
    for (int i = 0; i < ROWS; i++) begin
      s = 12'($urandom_range(100, 4000));
      x = 4'($urandom_range(0, 15));
      if (s < m_sad) begin
        m_sad = s; m_x = x; m_y = 4'(i);
      end
      send_row(s, x, 4'(i));
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      in_data  = {12'd5, 4'd9, 4'd9};
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || best_sad !== m_sad || best_x !== m_x || best_y !== m_y) begin
        n_fail++;
        $display("FAIL stall_stable c=%0d: ov=%0b sad=%0d x=%0d y=%0d, expected 1 %0d %0d %0d",
                 c, out_valid, best_sad, best_x, best_y, m_sad, m_x, m_y);
      end
    end
    in_valid = 1'b0;
    take_result("stall", m_sad, m_x, m_y);
  endtask

  task automatic test_abort();
    pulse_start();
    for (int i = 0; i < 7; i++) send_row(12'd10, 4'd1, 4'(i));
    start = 1'b1; in_valid = 1'b1; in_data = {12'd1, 4'd1, 4'd1};
    tick();
    start = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || best_sad !== 12'hFFF || best_x !== 4'd0 || best_y !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_reinit: busy=%0b sad=%h x=%0d y=%0d, expected 1 fff 0 0",
               busy, best_sad, best_x, best_y);
    end
    for (int i = 0; i < ROWS; i++) send_row((i == 4) ? 12'd90 : 12'(100 + i), 4'd5, 4'(i));
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_count: out_valid=%0b after 16 new rows, expected 1", out_valid);
    end
    take_result("abort", 12'd90, 4'd5, 4'd4);
  endtask

  task automatic test_back_to_back();
    // Window of idle-pattern rows: counted, but the initial best survives.
    pulse_start();
    for (int i = 0; i < ROWS; i++) send_row(12'hFFF, 4'd7, 4'(i));
    n_checks++;
    if (out_valid !== 1'b1 || best_sad !== 12'hFFF || best_x !== 4'd0 || best_y !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_pattern: ov=%0b sad=%h x=%0d y=%0d, expected 1 fff 0 0",
               out_valid, best_sad, best_x, best_y);
    end
    pulse_start();  // start without out_ready: ignored in HOLD
    n_checks++;
    if (out_valid !== 1'b1 || dbg_state !== ST_HOLD) begin
      n_fail++;
      $display("FAIL hold_start_ignored: ov=%0b st=%0d, expected 1 HOLD", out_valid, dbg_state);
    end
    exp_q.push_back({12'hFFF, 4'd0, 4'd0});
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || best_sad !== 12'hFFF) begin
      n_fail++;
      $display("FAIL chain_start: busy=%0b ov=%0b sad=%h, expected 1 0 fff", busy, out_valid, best_sad);
    end
    for (int i = 0; i < ROWS; i++) send_row(12'(300 + ((i * 7) % 16)), 4'd2, 4'(i));
    // (i*7)%16 is 0 only at i=0, so row 0 holds the minimum 300.
    take_result("chain", 12'd300, 4'd2, 4'd0);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 5; i++) send_row(12'd20, 4'd6, 4'(i));
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || best_sad !== 12'hFFF || best_x !== 4'd0 ||
        best_y !== 4'd0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%0b busy=%0b sad=%h x=%0d y=%0d st=%0d, expected 0 0 fff 0 0 0",
               out_valid, busy, best_sad, best_x, best_y, dbg_state);
    end
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_row(12'd5, 4'd1, 4'(i));
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_window c=%0d: ov=%0b busy=%0b, expected 0 0", i, out_valid, busy);
      end
    end
    pulse_start();
    for (int i = 0; i < ROWS; i++) send_row(12'(700 + i), 4'd1, 4'(i));
    take_result("post_reset", 12'd700, 4'd1, 4'd0);
  endtask

  task automatic test_early();
    pulse_start();
    send_row(12'd300, 4'd9, 4'd0);
    send_row(12'd250, 4'd9, 4'd1);
    send_row(12'd40,  4'd9, 4'd2);
`ifdef MV_SELECT_EARLY_TERM_EN
    n_checks++;
    if (out_valid !== 1'b1 || best_sad !== 12'd40) begin
      n_fail++;
      $display("FAIL early_term: ov=%0b sad=%0d, expected 1 40", out_valid, best_sad);
    end
`else
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_early_term: ov=%0b busy=%0b, expected 0 1", out_valid, busy);
    end
    for (int i = 3; i < ROWS; i++) send_row(12'd100, 4'd9, 4'(i));
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_window: out_valid=%0b after 16 rows, expected 1", out_valid);
    end
`endif
    take_result("early", 12'd40, 4'd9, 4'd2);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_descending();
    test_tie();
    test_hold_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_early();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
